disp_shift_buf: RTL and testbench

DISP_SHIFT_BUF -- requirements
Module: disp_shift_buf

---
 rtl/disp_shift_buf.sv | 134 +++++++++++++
 tb/tb_disp_shift_buf.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_shift_buf.sv
// disp_shift_buf: eight-digit hex scroll buffer for a seven-segment display.
// Each accepted byte scrolls in as two hex digits (high nibble first) over two
// cycles. Digits enter at d0 (rightmost) and push older digits left.
// Optional cursor blink on dp0 is enabled by defining DISP_SHIFT_BUF_BLINK_EN.
module disp_shift_buf #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       clear,
  output logic [3:0] d7,
  output logic [3:0] d6,
  output logic [3:0] d5,
  output logic [3:0] d4,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       dp7,
  output logic       dp6,
  output logic       dp5,
  output logic       dp4,
  output logic       dp3,
  output logic       dp2,
  output logic       dp1,
  output logic       dp0,
  output logic [7:0] blank,
  output logic [3:0] count
);

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFT_LO = 1'b1
  } state_t;

  state_t          state;
  logic [7:0][3:0] digits;
  logic [3:0]      lo_nib;

  // Digit counter increment, holding at eight once the display is full.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= 4'd8) ? 4'd8 : c + 4'd1;
  endfunction

  // Positions at or beyond the written-digit count have never been written.
  function automatic logic [7:0] blank_mask(input logic [3:0] c);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (i >= int'(c));
    return m;
  endfunction

  // Elaboration-time guard on the blink divider range.
  if (BLINK_DIV < 2 || BLINK_DIV > (1 << 26)) begin : g_bad_blink_div
    $error("disp_shift_buf: BLINK_DIV out of range");
  end

  // Ready only in IDLE; a clear in the same cycle refuses the byte.
  assign ready = (state == IDLE) && !clear;

  assign d7 = digits[7];
  assign d6 = digits[6];
  assign d5 = digits[5];
  assign d4 = digits[4];
  assign d3 = digits[3];
  assign d2 = digits[2];
  assign d1 = digits[1];
  assign d0 = digits[0];

  assign dp7 = 1'b0;
  assign dp6 = 1'b0;
  assign dp5 = 1'b0;
  assign dp4 = 1'b0;
  assign dp3 = 1'b0;
  assign dp2 = 1'b0;
  assign dp1 = 1'b0;

  // Two-state scroll FSM: high nibble on the transfer, low nibble the cycle after.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state  <= IDLE;
      digits <= '0;
      lo_nib <= 4'd0;
      count  <= 4'd0;
      blank  <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            digits <= {digits[6:0], data[7:4]};
            lo_nib <= data[3:0];
            count  <= sat_inc(count);
            blank  <= blank_mask(sat_inc(count));
            state  <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          digits <= {digits[6:0], lo_nib};
          count  <= sat_inc(count);
          blank  <= blank_mask(sat_inc(count));
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISP_SHIFT_BUF_BLINK_EN
  localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);

  logic [25:0] blink_cnt;
  logic        dp0_q;

  // Cursor blink: counter wraps every BLINK_DIV cycles and flips dp0 on each wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      blink_cnt <= 26'd0;
      dp0_q     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= 26'd0;
      dp0_q     <= ~dp0_q;
    end else begin
      blink_cnt <= blink_cnt + 26'd1;
    end
  end

  assign dp0 = dp0_q;
`else
  assign dp0 = 1'b0;
`endif

endmodule

// File: tb/tb_disp_shift_buf.sv
// Self-checking bench for disp_shift_buf. The reference model keeps the stream
// of written nibbles as a queue; displayed digits are the newest eight entries.
module tb_disp_shift_buf;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0;
  logic       dp7, dp6, dp5, dp4, dp3, dp2, dp1, dp0;
  logic [7:0] blank;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] hist[$];
  bit         pend = 1'b0;
  logic [3:0] pend_nib = 4'd0;
  int         cyc = 0;

  disp_shift_buf #(.BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
    .clear(clear),
    .d7(d7), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .dp7(dp7), .dp6(dp6), .dp5(dp5), .dp4(dp4), .dp3(dp3), .dp2(dp2),
    .dp1(dp1), .dp0(dp0),
    .blank(blank), .count(count)
  );

  always #5 clk = ~clk;

  wire [31:0] obs_digits = {d7, d6, d5, d4, d3, d2, d1, d0};
  wire [7:0]  obs_dp     = {dp7, dp6, dp5, dp4, dp3, dp2, dp1, dp0};

  // Advance one clock and apply the same edge to the model.
  task automatic edge_tick();
    @(posedge clk);
    #1;
    if (reset || clear) begin
      hist.delete();
      pend     = 1'b0;
      pend_nib = 4'd0;
      cyc      = 0;
    end else begin
      cyc++;
      if (pend) begin
        hist.push_back(pend_nib);
        pend = 1'b0;
      end else if (valid) begin
        hist.push_back(data[7:4]);
        pend_nib = data[3:0];
        pend     = 1'b1;
      end
      while (hist.size() > 8) void'(hist.pop_front());
    end
  endtask

  function automatic logic [31:0] exp_digits();
    logic [31:0] r;
    int n;
    n = hist.size();
    r = '0;
    for (int i = 0; i < 8; i++) if (i < n) r[i*4 +: 4] = hist[n-1-i];
    return r;
  endfunction

  function automatic logic [3:0] exp_count();
    return 4'(hist.size());
  endfunction

  function automatic logic [7:0] exp_blank();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (i >= hist.size());
    return b;
  endfunction

  function automatic logic [7:0] exp_dp();
`ifdef DISP_SHIFT_BUF_BLINK_EN
    return {7'd0, ((cyc / BD) % 2) == 1};
`else
    return 8'd0;
`endif
  endfunction

  function automatic logic exp_ready();
    return !pend && !clear;
  endfunction

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; valid = 1'b0;
    edge_tick();
    edge_tick();
    reset = 1'b0;
    #1;
    checks++;
    if (obs_digits !== 32'd0) begin
      failures++; $display("FAIL reset_digits got=%h exp=%h", obs_digits, 32'd0);
    end
    checks++;
    if (count !== 4'd0 || blank !== 8'hFF) begin
      failures++; $display("FAIL reset_count_blank got=%0d/%h exp=0/ff", count, blank);
    end
    checks++;
    if (ready !== 1'b1 || obs_dp !== 8'd0) begin
      failures++; $display("FAIL reset_ready_dp got=%b/%h exp=1/00", ready, obs_dp);
    end
  endtask

  task automatic test_single_byte();
    valid = 1'b1; data = 8'hA5;
    edge_tick();
    valid = 1'b0; data = 8'h00;
    #1;
    checks++;
    if (d0 !== 4'hA || count !== 4'd1 || ready !== 1'b0) begin
      failures++; $display("FAIL a5_first got d0=%h cnt=%0d rdy=%b exp d0=a cnt=1 rdy=0", d0, count, ready);
    end
    edge_tick();
    checks++;
    if (d1 !== 4'hA || d0 !== 4'h5 || count !== 4'd2 || blank !== 8'hFC || ready !== 1'b1) begin
      failures++;
      $display("FAIL a5_second got d1=%h d0=%h cnt=%0d blank=%h rdy=%b exp a 5 2 fc 1", d1, d0, count, blank, ready);
    end
    checks++;
    if (obs_digits !== exp_digits()) begin
      failures++; $display("FAIL a5_model got=%h exp=%h", obs_digits, exp_digits());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    int idx, edges;
    logic took;
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    reset = 1'b1; edge_tick(); reset = 1'b0;
    idx = 0; edges = 0;
    while (idx < 5 && edges < 40) begin
      valid = 1'b1; data = bytes[idx];
      #1;
      took = ready;
      checks++;
      if (ready !== exp_ready()) begin
        failures++; $display("FAIL b2b_ready edge=%0d got=%b exp=%b", edges, ready, exp_ready());
      end
      edge_tick();
      edges++;
      if (took) idx++;
    end
    valid = 1'b0;
    edge_tick();
    edges++;
    checks++;
    if (edges !== 10) begin
      failures++; $display("FAIL b2b_edges got=%0d exp=10", edges);
    end
    checks++;
    if (obs_digits !== 32'h3456789A || count !== 4'd8 || blank !== 8'h00) begin
      failures++; $display("FAIL b2b_final got=%h cnt=%0d blank=%h exp=3456789a 8 00", obs_digits, count, blank);
    end
  endtask

  task automatic test_clear_collision();
    clear = 1'b1; valid = 1'b1; data = 8'hFF;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL clear_ready got=%b exp=0", ready);
    end
    edge_tick();
    clear = 1'b0; valid = 1'b0;
    #1;
    checks++;
    if (obs_digits !== 32'd0 || count !== 4'd0 || blank !== 8'hFF) begin
      failures++; $display("FAIL clear_state got=%h cnt=%0d blank=%h exp=0 0 ff", obs_digits, count, blank);
    end
  endtask

  task automatic test_abort_shift_lo(input bit use_reset);
    logic bad;
    valid = 1'b1; data = 8'hC3;
    edge_tick();
    valid = 1'b0;
    if (use_reset) reset = 1'b1; else clear = 1'b1;
    edge_tick();
    reset = 1'b0; clear = 1'b0;
    #1;
    checks++;
    if (d0 !== 4'h0 || count !== 4'd0 || ready !== 1'b1) begin
      failures++; $display("FAIL abort_%0d got d0=%h cnt=%0d rdy=%b exp 0 0 1", use_reset, d0, count, ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_tick();
      if (obs_digits !== 32'd0 || count !== 4'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL abort_leak_%0d got=%h cnt=%0d exp=0 0", use_reset, obs_digits, count);
    end
  endtask

  task automatic test_blink();
    int errs;
    reset = 1'b1; edge_tick(); reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      edge_tick();
      if (obs_dp !== exp_dp()) begin
        errs++;
        if (errs < 4) $display("FAIL blink cyc=%0d got=%h exp=%h", cyc, obs_dp, exp_dp());
      end
    end
    checks++;
    if (errs != 0) failures++;
  endtask

  task automatic test_random();
    int errs;
    logic [52:0] obs, exp;
    reset = 1'b1; edge_tick(); reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      clear = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 49) == 0);
      #1;
      if (ready !== exp_ready()) begin
        errs++;
        if (errs < 6) $display("FAIL rand_ready i=%0d got=%b exp=%b", i, ready, exp_ready());
      end
      edge_tick();
      obs = {obs_digits, blank, count, obs_dp, 1'b0};
      exp = {exp_digits(), exp_blank(), exp_count(), exp_dp(), 1'b0};
      if (obs !== exp) begin
        errs++;
        if (errs < 6) $display("FAIL rand_state i=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    reset = 1'b0; clear = 1'b0; valid = 1'b0;
    checks++;
    if (errs != 0) failures++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_clear_collision();
    test_abort_shift_lo(1'b1);
    test_abort_shift_lo(1'b0);
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
